core_rvfi_trace: RTL and testbench
==================================

Name: core_rvfi_trace

Overview:
- Downstream consumer of the core's registered RVFI retirement port.
- Captures each retired-instruction record into a small FIFO, tags it with a sequence number and drains it over a valid/ready stream to the trace sink (sim dumper or debug capture).
- Counts records dropped when the sink stalls, so gaps in the sequence numbers are explainable.
- Compiled only under RVFI, like the rest of the formal/trace path.

Parameters:
- XLEN, 64, data/PC width.
- ILEN, 32, instruction width.
- DEPTH, 8, FIFO entries; power of 2, minimum 2.
- SEQW, 16, sequence-number width.

Ports:
- g_clk  in  1  clock.
- g_resetn  in  1  reset.
- rvfi_valid  in  1  retirement strobe; one record per high cycle.
- rvfi_insn  in  ILEN  retired instruction.
- rvfi_intr  in  1  first instruction of a trap handler.
- rvfi_trap  in  1  instruction trapped.
- rvfi_rd_addr  in  5  destination register.
- rvfi_rd_wdata  in  XLEN  destination write data.
- rvfi_pc_rdata  in  XLEN  PC of the retired instruction.
- rvfi_mem_addr  in  XLEN  memory address; used only with the optional feature.
- rvfi_mem_rmask  in  XLEN/8  memory read mask; used only with the optional feature.
- rvfi_mem_wmask  in  XLEN/8  memory write mask; used only with the optional feature.
- rvfi_mem_wdata  in  XLEN  memory write data; used only with the optional feature.
- trace_en  in  1  capture enable.
- trace_clr  in  1  synchronous clear of the FIFO, counters and flag.
- t_valid  out  1  record available.
- t_ready  in  1  sink accepts the record.
- t_data  out  RECW  packed record; RECW is defined in the package.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_count  out  16  dropped records, saturating.
- overflow  out  1  sticky drop flag.

Behaviour:
- Clock and reset: reset g_resetn, synchronous, active-low; clock g_clk.
- Reset values: t_valid=0, level=0, drop_count=0, overflow=0, sequence counter=0, both pointers=0. t_data is don't-care while t_valid=0.
- Record packing, MSB to LSB: seq[SEQW], intr, trap, rd_addr[5], pc_rdata, insn, rd_wdata. Base RECW = SEQW+7+2*XLEN+ILEN = 183 at defaults.
- Capture event: rvfi_valid && trace_en.
  - The sequence counter increments on every capture event, including dropped ones, and wraps modulo 2^SEQW.
  - The record carries the pre-increment value.
- Pop: t_valid && t_ready.
- Push: capture event && (!full || pop). Writing into a full FIFO on the same cycle as a pop is legal, and level stays DEPTH.
- Drop: capture event && full && !pop.
  - drop_count increments, saturating at 16'hFFFF.
  - overflow is set.
- Storage and pointers:
  - Registered array.
  - Pointers are $clog2(DEPTH)+1 bits: full when the MSBs differ and the low bits match; empty when the pointers are equal.
- Output timing:
  - t_valid = !empty.
  - t_data = entry at the read pointer (first-word fall-through).
  - Latency is 1 cycle: a capture at edge N gives t_valid=1 after edge N.
- t_data must stay stable while t_valid && !t_ready.
- level: +1 on push only, -1 on pop only, unchanged on both or neither.
- trace_clr:
  - Empties the FIFO and zeros the sequence counter, drop_count and overflow.
  - Takes priority over a same-cycle push, pop or drop; that record is discarded and not counted.
- trace_en=0: no pushes and no sequence increment; draining continues normally.
- Reset asserted mid-stream discards all contents; there is no partial-record state.

Optional Feature:
- Macro: CORE_RVFI_TRACE_MEM_EN.
- Defined:
  - Record gains mem_addr, mem_rmask, mem_wmask, mem_wdata, appended below rd_wdata in that order.
  - RECW grows by 2*XLEN+2*XLEN/8 (+144, giving 327).
- Undefined:
  - The mem ports still exist but are unused.
  - RECW stays 183; there is no extra storage.

Decomposition:
- Package core_rvfi_trace_pkg holds:
  - RECW_BASE and RECW_MEM localparams.
  - Field offset constants.
  - A packed struct typedef for the record, so the bench can unpack it.
- Sub-module core_rvfi_trace_fifo: a generic DEPTH x WIDTH synchronous FIFO exposing push, pop, full, empty and level, with FWFT read.
- The top level holds packing, sequence counter, drop logic and clear.

Test Plan:
- Single capture: rvfi_valid for 1 cycle with pc=0x8000_0000, insn=0x00a00093, rd=1, wdata=10, t_ready=1 -> t_valid one cycle later with seq=0 and the matching fields; level 1 then 0.
- Backpressure fill: t_ready=0 and 10 consecutive captures -> level reaches 8, drop_count=2, overflow=1. Then t_ready=1 -> 8 records with seq 0..7; the next capture carries seq=10.
- Full with simultaneous push and pop: FIFO full, capture with t_ready=1 -> no drop, level stays 8, the new record emerges last.
- Stall stability: t_valid=1 with t_ready low for 5 cycles while captures continue -> t_data unchanged across all 5 cycles.
- Clear priority: trace_clr together with a capture and a pop -> level=0, drop_count=0, overflow=0; the next capture has seq=0.
- Gating and wrap: trace_en=0 for 3 strobes -> no records. Force seq to 0xFFFF by 65535 captures -> the next two records are 0xFFFF then 0x0000. With CORE_RVFI_TRACE_MEM_EN, a store of addr 0x1000, wmask 0x0F -> the record mem fields match.

Source files
------------

// File: rtl/core_rvfi_trace_pkg.sv
// Shared widths, field offsets and the packed trace record for core_rvfi_trace.
// CORE_RVFI_TRACE_MEM_EN appends the memory-access fields to the record.
package core_rvfi_trace_pkg;

    localparam int XLEN_DEF = 64;
    localparam int ILEN_DEF = 32;
    localparam int SEQW_DEF = 16;

    localparam int RECW_BASE = SEQW_DEF + 7 + 2 * XLEN_DEF + ILEN_DEF;
    localparam int RECW_MEM  = 2 * XLEN_DEF + 2 * (XLEN_DEF / 8);

`ifdef CORE_RVFI_TRACE_MEM_EN
    localparam int RECW = RECW_BASE + RECW_MEM;
`else
    localparam int RECW = RECW_BASE;
`endif

    // Bit offsets (from the LSB) of each field at the default widths.
    localparam int OFF_RD_WDATA = RECW - RECW_BASE;
    localparam int OFF_INSN     = OFF_RD_WDATA + XLEN_DEF;
    localparam int OFF_PC       = OFF_INSN + ILEN_DEF;
    localparam int OFF_RD_ADDR  = OFF_PC + XLEN_DEF;
    localparam int OFF_TRAP     = OFF_RD_ADDR + 5;
    localparam int OFF_INTR     = OFF_TRAP + 1;
    localparam int OFF_SEQ      = OFF_INTR + 1;

    typedef struct packed {
        logic [SEQW_DEF-1:0]     seq;
        logic                    intr;
        logic                    trap;
        logic [4:0]              rd_addr;
        logic [XLEN_DEF-1:0]     pc_rdata;
        logic [ILEN_DEF-1:0]     insn;
        logic [XLEN_DEF-1:0]     rd_wdata;
`ifdef CORE_RVFI_TRACE_MEM_EN
        logic [XLEN_DEF-1:0]     mem_addr;
        logic [XLEN_DEF/8-1:0]   mem_rmask;
        logic [XLEN_DEF/8-1:0]   mem_wmask;
        logic [XLEN_DEF-1:0]     mem_wdata;
`endif
    } trace_rec_t;

    function automatic int rec_width(input int xlen, input int ilen, input int seqw);
`ifdef CORE_RVFI_TRACE_MEM_EN
        return seqw + 7 + 2 * xlen + ilen + 2 * xlen + 2 * (xlen / 8);
`else
        return seqw + 7 + 2 * xlen + ilen;
`endif
    endfunction

endpackage

// File: rtl/core_rvfi_trace_fifo.sv
// Generic DEPTH x WIDTH synchronous FIFO with first-word fall-through read.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module core_rvfi_trace_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     g_clk,
    input  logic                     g_resetn,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clr_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push_i) wptr_d = wptr_q + PTR_ONE;
            if (pop_i)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // When full, the write slot equals the slot being popped this cycle, so
    // the new entry lands behind everything already queued.
    always_ff @(posedge g_clk) begin
        if (push_i && !clr_i) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign level_o = wptr_q - rptr_q;

endmodule

// File: rtl/core_rvfi_trace.sv
// RVFI retirement trace capture: sequence tagging, FIFO buffering, drop accounting.
// Define CORE_RVFI_TRACE_MEM_EN to include the memory-access fields in each record.
module core_rvfi_trace
    import core_rvfi_trace_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int ILEN  = 32,
    parameter int DEPTH = 8,
    parameter int SEQW  = 16
) (
    input  logic                                  g_clk,
    input  logic                                  g_resetn,
    input  logic                                  rvfi_valid,
    input  logic [ILEN-1:0]                       rvfi_insn,
    input  logic                                  rvfi_intr,
    input  logic                                  rvfi_trap,
    input  logic [4:0]                            rvfi_rd_addr,
    input  logic [XLEN-1:0]                       rvfi_rd_wdata,
    input  logic [XLEN-1:0]                       rvfi_pc_rdata,
    input  logic [XLEN-1:0]                       rvfi_mem_addr,
    input  logic [XLEN/8-1:0]                     rvfi_mem_rmask,
    input  logic [XLEN/8-1:0]                     rvfi_mem_wmask,
    input  logic [XLEN-1:0]                       rvfi_mem_wdata,
    input  logic                                  trace_en,
    input  logic                                  trace_clr,
    output logic                                  t_valid,
    input  logic                                  t_ready,
    output logic [rec_width(XLEN, ILEN, SEQW)-1:0] t_data,
    output logic [$clog2(DEPTH):0]                level,
    output logic [15:0]                           drop_count,
    output logic                                  overflow
);

    localparam int W = rec_width(XLEN, ILEN, SEQW);

    logic [SEQW-1:0] seq_q, seq_d;
    logic [15:0]     drop_q, drop_d;
    logic            ovf_q, ovf_d;
    logic [W-1:0]    rec;
    logic            capture, pop, push, drop, full, empty;

`ifdef CORE_RVFI_TRACE_MEM_EN
    assign rec = {seq_q, rvfi_intr, rvfi_trap, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn,
                  rvfi_rd_wdata, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_wdata};
`else
    assign rec = {seq_q, rvfi_intr, rvfi_trap, rvfi_rd_addr, rvfi_pc_rdata, rvfi_insn,
                  rvfi_rd_wdata};
    logic unused_mem;
    assign unused_mem = ^{rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_wdata};
`endif

    // Stream handshake: a record transfers on any cycle with t_valid && t_ready;
    // t_valid never depends on t_ready and t_data holds while stalled.
    assign capture = rvfi_valid && trace_en;
    assign t_valid = !empty;
    assign pop     = t_valid && t_ready;
    assign push    = capture && (!full || pop);
    assign drop    = capture && full && !pop;

    always_comb begin
        seq_d  = seq_q;
        drop_d = drop_q;
        ovf_d  = ovf_q;
        if (trace_clr) begin
            seq_d  = '0;
            drop_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (capture) seq_d = seq_q + SEQW'(1);
            if (drop) begin
                if (drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            seq_q  <= '0;
            drop_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            drop_q <= drop_d;
            ovf_q  <= ovf_d;
        end
    end

    core_rvfi_trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (W)
    ) u_fifo (
        .g_clk    (g_clk),
        .g_resetn (g_resetn),
        .clr_i    (trace_clr),
        .push_i   (push),
        .wdata_i  (rec),
        .pop_i    (pop),
        .rdata_o  (t_data),
        .full_o   (full),
        .empty_o  (empty),
        .level_o  (level)
    );

    assign drop_count = drop_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_core_rvfi_trace.sv
// Randomized and directed bench for core_rvfi_trace against a queue-based record model.
`timescale 1ns/1ps
module tb_core_rvfi_trace;
    import core_rvfi_trace_pkg::*;

    localparam int XLEN  = 64;
    localparam int ILEN  = 32;
    localparam int DEPTH = 8;
    localparam int SEQW  = 16;
    localparam int W     = $bits(trace_rec_t);

    logic              g_clk, g_resetn;
    logic              rvfi_valid, rvfi_intr, rvfi_trap;
    logic [ILEN-1:0]   rvfi_insn;
    logic [4:0]        rvfi_rd_addr;
    logic [XLEN-1:0]   rvfi_rd_wdata, rvfi_pc_rdata, rvfi_mem_addr, rvfi_mem_wdata;
    logic [XLEN/8-1:0] rvfi_mem_rmask, rvfi_mem_wmask;
    logic              trace_en, trace_clr, t_valid, t_ready, overflow;
    logic [W-1:0]      t_data;
    logic [3:0]        level;
    logic [15:0]       drop_count;

    core_rvfi_trace #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH), .SEQW(SEQW)) dut (
        .g_clk(g_clk), .g_resetn(g_resetn), .rvfi_valid(rvfi_valid), .rvfi_insn(rvfi_insn),
        .rvfi_intr(rvfi_intr), .rvfi_trap(rvfi_trap), .rvfi_rd_addr(rvfi_rd_addr),
        .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_pc_rdata(rvfi_pc_rdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_wdata(rvfi_mem_wdata),
        .trace_en(trace_en), .trace_clr(trace_clr), .t_valid(t_valid), .t_ready(t_ready),
        .t_data(t_data), .level(level), .drop_count(drop_count), .overflow(overflow)
    );

    // clock / reset
    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    // scoreboard state
    trace_rec_t      exp_q[$];
    logic [SEQW-1:0] m_seq;
    logic [15:0]     m_drops;
    logic            m_ovf;
    int              n_checks, n_err;
    logic            chk_en;

    task automatic check_v(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_r(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic trace_rec_t model_rec();
        trace_rec_t r;
        r.seq      = m_seq;
        r.intr     = rvfi_intr;
        r.trap     = rvfi_trap;
        r.rd_addr  = rvfi_rd_addr;
        r.pc_rdata = rvfi_pc_rdata;
        r.insn     = rvfi_insn;
        r.rd_wdata = rvfi_rd_wdata;
`ifdef CORE_RVFI_TRACE_MEM_EN
        r.mem_addr  = rvfi_mem_addr;
        r.mem_rmask = rvfi_mem_rmask;
        r.mem_wmask = rvfi_mem_wmask;
        r.mem_wdata = rvfi_mem_wdata;
`endif
        return r;
    endfunction

    // reference model: a bounded queue of records, updated once per clock edge
    always @(posedge g_clk) begin
        bit         popped, cap;
        trace_rec_t r;
        if (!g_resetn || trace_clr) begin
            exp_q.delete();
            m_seq   = '0;
            m_drops = '0;
            m_ovf   = 1'b0;
        end else begin
            popped = (exp_q.size() != 0) && t_ready;
            cap    = rvfi_valid && trace_en;
            r      = model_rec();
            if (popped) void'(exp_q.pop_front());
            if (cap) begin
                if (exp_q.size() < DEPTH) exp_q.push_back(r);
                else begin
                    if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
                    m_ovf = 1'b1;
                end
                m_seq = m_seq + 16'd1;
            end
        end
    end

    // compare process
    always @(negedge g_clk) begin
        if (chk_en) begin
            check_v("t_valid", 64'(t_valid), 64'(exp_q.size() != 0));
            check_v("level", 64'(level), 64'(exp_q.size()));
            check_v("drop_count", 64'(drop_count), 64'(m_drops));
            check_v("overflow", 64'(overflow), 64'(m_ovf));
            if (exp_q.size() != 0) check_r("t_data", t_data, exp_q[0]);
        end
    end

    // driver tasks
    task automatic rand_fields();
        rvfi_insn      = $urandom;
        rvfi_intr      = 1'($urandom_range(0, 1));
        rvfi_trap      = 1'($urandom_range(0, 1));
        rvfi_rd_addr   = 5'($urandom_range(0, 31));
        rvfi_rd_wdata  = {$urandom, $urandom};
        rvfi_pc_rdata  = {$urandom, $urandom};
        rvfi_mem_addr  = {$urandom, $urandom};
        rvfi_mem_rmask = 8'($urandom_range(0, 255));
        rvfi_mem_wmask = 8'($urandom_range(0, 255));
        rvfi_mem_wdata = {$urandom, $urandom};
    endtask

    task automatic tick();
        @(negedge g_clk);
    endtask

    task automatic capture_one();
        rand_fields();
        rvfi_valid = 1'b1;
        tick();
        rvfi_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        trace_clr = 1'b1;
        tick();
        trace_clr = 1'b0;
    endtask

    trace_rec_t r;

    initial begin
        n_checks = 0; n_err = 0; chk_en = 1'b0;
        g_resetn = 1'b0; rvfi_valid = 1'b0; trace_en = 1'b1; trace_clr = 1'b0; t_ready = 1'b0;
        rand_fields();
        repeat (3) tick();
        chk_en = 1'b1;
        check_v("rst_t_valid", 64'(t_valid), 64'd0);
        check_v("rst_level", 64'(level), 64'd0);
        check_v("rst_drop", 64'(drop_count), 64'd0);
        check_v("rst_ovf", 64'(overflow), 64'd0);
        g_resetn = 1'b1;
        tick();

        // single capture
        rand_fields();
        rvfi_pc_rdata = 64'h8000_0000; rvfi_insn = 32'h00a00093; rvfi_rd_addr = 5'd1;
        rvfi_rd_wdata = 64'd10; rvfi_intr = 1'b0; rvfi_trap = 1'b0; t_ready = 1'b1;
        rvfi_valid = 1'b1;
        tick();
        rvfi_valid = 1'b0;
        r = t_data;
        check_v("t1_valid", 64'(t_valid), 64'd1);
        check_v("t1_seq", 64'(r.seq), 64'd0);
        check_v("t1_pc", r.pc_rdata, 64'h8000_0000);
        check_v("t1_insn", 64'(r.insn), 64'h00a00093);
        check_v("t1_rd", 64'(r.rd_addr), 64'd1);
        check_v("t1_wdata", r.rd_wdata, 64'd10);
        check_v("t1_level1", 64'(level), 64'd1);
        tick();
        check_v("t1_level0", 64'(level), 64'd0);

        // backpressure fill with drops, then drain in order
        pulse_clr();
        t_ready = 1'b0;
        for (int i = 0; i < 10; i++) capture_one();
        check_v("t2_level", 64'(level), 64'd8);
        check_v("t2_drop", 64'(drop_count), 64'd2);
        check_v("t2_ovf", 64'(overflow), 64'd1);
        t_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = t_data;
            check_v("t2_seq", 64'(r.seq), 64'(i));
            tick();
        end
        check_v("t2_empty", 64'(level), 64'd0);
        capture_one();
        r = t_data;
        check_v("t2_seq10", 64'(r.seq), 64'd10);
        tick();

        // full with simultaneous push and pop, then stall stability
        pulse_clr();
        t_ready = 1'b0;
        for (int i = 0; i < 8; i++) capture_one();
        t_ready = 1'b1;
        capture_one();
        t_ready = 1'b0;
        check_v("t3_level", 64'(level), 64'd8);
        check_v("t3_nodrop", 64'(drop_count), 64'd0);
        for (int i = 0; i < 5; i++) begin
            capture_one();
            r = t_data;
            check_v("t4_stall_seq", 64'(r.seq), 64'd1);
        end
        check_v("t4_drop", 64'(drop_count), 64'd5);
        t_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = t_data;
            check_v("t3_order", 64'(r.seq), 64'(i + 1));
            tick();
        end

        // clear beats a same-cycle capture and pop
        t_ready = 1'b0;
        for (int i = 0; i < 9; i++) capture_one();
        t_ready = 1'b1; trace_clr = 1'b1; rand_fields(); rvfi_valid = 1'b1;
        tick();
        trace_clr = 1'b0; rvfi_valid = 1'b0;
        check_v("t5_level", 64'(level), 64'd0);
        check_v("t5_drop", 64'(drop_count), 64'd0);
        check_v("t5_ovf", 64'(overflow), 64'd0);
        capture_one();
        r = t_data;
        check_v("t5_seq0", 64'(r.seq), 64'd0);
        tick();

        // capture gating
        trace_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            capture_one();
            check_v("t6_gated", 64'(level), 64'd0);
        end
        trace_en = 1'b1;

        // sequence wrap
        pulse_clr();
        rvfi_valid = 1'b1;
        for (int i = 0; i < 65535; i++) begin
            rand_fields();
            tick();
        end
        rvfi_valid = 1'b0;
        capture_one();
        r = t_data;
        check_v("t6_seq_ffff", 64'(r.seq), 64'hFFFF);
        capture_one();
        r = t_data;
        check_v("t6_seq_wrap", 64'(r.seq), 64'h0);
        tick();

`ifdef CORE_RVFI_TRACE_MEM_EN
        rand_fields();
        rvfi_mem_addr = 64'h1000; rvfi_mem_rmask = 8'h00; rvfi_mem_wmask = 8'h0F;
        rvfi_mem_wdata = 64'hDEAD_BEEF;
        rvfi_valid = 1'b1;
        tick();
        rvfi_valid = 1'b0;
        r = t_data;
        check_v("mem_addr", r.mem_addr, 64'h1000);
        check_v("mem_rmask", 64'(r.mem_rmask), 64'h00);
        check_v("mem_wmask", 64'(r.mem_wmask), 64'h0F);
        check_v("mem_wdata", r.mem_wdata, 64'hDEAD_BEEF);
        tick();
`endif

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            rand_fields();
            rvfi_valid = ($urandom_range(0, 3) != 0);
            trace_en   = ($urandom_range(0, 7) != 0);
            t_ready    = (i < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            trace_clr  = ($urandom_range(0, 99) == 0);
            tick();
        end
        rvfi_valid = 1'b0; trace_clr = 1'b0; trace_en = 1'b1;

        // reset mid-stream
        t_ready = 1'b0;
        for (int i = 0; i < 4; i++) capture_one();
        g_resetn = 1'b0;
        tick();
        g_resetn = 1'b1;
        check_v("rst_mid_valid", 64'(t_valid), 64'd0);
        check_v("rst_mid_level", 64'(level), 64'd0);
        capture_one();
        r = t_data;
        check_v("rst_mid_seq", 64'(r.seq), 64'd0);
        t_ready = 1'b1;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
